// File: rtl/des_f_pipe_if.sv
// Handshake bundle for des_f_pipe: operand side (R, K, tag) and result side (f, tag).
interface des_f_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:32]      R_in;
    logic [1:48]      K_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [1:32]      f_out;
    logic [TAG_W-1:0] tag_out;

    modport slave (
        input  in_valid, R_in, K_in, tag_in, out_ready,
        output in_ready, out_valid, f_out, tag_out
    );

    modport master (
        output in_valid, R_in, K_in, tag_in, out_ready,
        input  in_ready, out_valid, f_out, tag_out
    );
endinterface

// File: rtl/des_f_pipe.sv
// DES round function f(R,K) = P(S1..S8(E(R) ^ K)) as a valid/ready pipeline.
// Define DES_F_SBOX_STAGE_EN to register the S-box outputs ahead of P (3-cycle latency).
module des_f_pipe #(
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    des_f_pipe_if.slave bus
);
    // P table, entry for output bit 1 in the most significant slot
    localparam logic [191:0] P_TAB = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    // S1..S8, each 4 rows x 16 columns of nibbles, row 0 column 0 in the top nibble
    localparam logic [0:7][255:0] SBOX_TAB = {
        {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    function automatic logic [3:0] sbox_lookup(input logic [255:0] tab, input logic [5:0] six);
        int idx;
        idx = {26'd0, six[5], six[0], six[4:1]};
        return tab[(63 - idx) * 4 +: 4];
    endfunction

    logic             s1_valid_reg;
    logic             s2_valid_reg;
    logic [1:48]      x_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic [TAG_W-1:0] s2_tag_reg;
    logic [1:32]      f_reg;
    logic             s1_load;
    logic             s1_take;
    logic             s2_load;
    logic [1:48]      e_r;
    logic [1:32]      sbox_out;
    logic [1:32]      p_in;
    logic [1:32]      p_out;
    logic [TAG_W-1:0] p_tag;
    logic             p_valid;

    // E expansion: group g repeats R bits 4g..4g+5, with 0 wrapping to 32 and 33 to 1
    for (genvar gi = 0; gi < 48; gi++) begin : g_expand
        localparam int SRC = ((4 * (gi / 6) + (gi % 6) + 31) % 32) + 1;
        assign e_r[gi + 1] = bus.R_in[SRC];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
        assign sbox_out[gi * 4 + 1 +: 4] = sbox_lookup(SBOX_TAB[gi], x_reg[gi * 6 + 1 +: 6]);
    end

`ifdef DES_F_SBOX_STAGE_EN
    logic             sb_valid_reg;
    logic [1:32]      sb_reg;
    logic [TAG_W-1:0] sb_tag_reg;
    logic             sb_load;

    assign sb_load = s1_valid_reg & (~sb_valid_reg | s2_load);
    assign s1_take = sb_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid_reg <= 1'b0;
            sb_reg       <= '0;
            sb_tag_reg   <= '0;
        end else begin
            sb_valid_reg <= sb_load | (sb_valid_reg & ~s2_load);
            if (sb_load) begin
                sb_reg     <= sbox_out;
                sb_tag_reg <= s1_tag_reg;
            end
        end
    end

    assign p_in    = sb_reg;
    assign p_tag   = sb_tag_reg;
    assign p_valid = sb_valid_reg;
`else
    assign s1_take = s2_load;
    assign p_in    = sbox_out;
    assign p_tag   = s1_tag_reg;
    assign p_valid = s1_valid_reg;
`endif

    for (genvar gi = 1; gi <= 32; gi++) begin : g_perm
        assign p_out[gi] = p_in[P_TAB[(32 - gi) * 6 +: 6]];
    end

    // Stage 1 frees up in the same cycle its contents move on, so a full pipe streams
    assign s2_load      = p_valid & (~s2_valid_reg | bus.out_ready);
    assign bus.in_ready = ~s1_valid_reg | s1_take;
    assign s1_load      = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            x_reg        <= '0;
            s1_tag_reg   <= '0;
        end else begin
            s1_valid_reg <= s1_load | (s1_valid_reg & ~s1_take);
            if (s1_load) begin
                x_reg      <= e_r ^ bus.K_in;
                s1_tag_reg <= bus.tag_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            f_reg        <= '0;
            s2_tag_reg   <= '0;
        end else begin
            s2_valid_reg <= s2_load | (s2_valid_reg & ~bus.out_ready);
            if (s2_load) begin
                f_reg      <= p_out;
                s2_tag_reg <= p_tag;
            end
        end
    end

    assign bus.out_valid = s2_valid_reg;
    assign bus.f_out     = f_reg;
    assign bus.tag_out   = s2_tag_reg;
endmodule

// File: tb/tb_des_f_pipe.sv
// Bench for des_f_pipe: directed vector table, handshake corner sequences and a
// randomized run, all scored against a table-based DES f model.
module tb_des_f_pipe;
    localparam int TAG_W = 4;
`ifdef DES_F_SBOX_STAGE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_f_pipe_if #(.TAG_W(TAG_W)) bus ();
    des_f_pipe #(.TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                     12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                     24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    // Reference f: bit n (1 = MSB) of a w-bit word lives at position w-n
    function automatic logic [31:0] golden_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] f;
        int v;
        int row;
        int col;
        for (int n = 1; n <= 48; n++) x[48 - n] = r[32 - E_T[n - 1]] ^ k[48 - n];
        s = '0;
        for (int b = 0; b < 8; b++) begin
            v   = int'(x[47 - 6 * b -: 6]);
            row = ((v >> 5) & 1) * 2 + (v & 1);
            col = (v >> 1) & 15;
            s   = (s << 4) | 32'(SB[b][row * 16 + col]);
        end
        for (int n = 1; n <= 32; n++) f[32 - n] = s[32 - P_T[n - 1]];
        return f;
    endfunction

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0]      f;
        logic [TAG_W-1:0] tag;
        int               acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   out_cyc_q[$];
    int   cyc = 0;
    int   n_out = 0;
    bit   chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted operand must come out once, in order
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                check("pending_expect", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("f_out", 64'(bus.f_out), 64'(e.f));
                    check("tag_out", 64'(bus.tag_out), 64'(e.tag));
                    if (chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
                end
                $display("xfer %0d: cyc=%0d tag=%0h f_out=%08h", n_out, cyc, bus.tag_out, bus.f_out);
                n_out++;
                out_cyc_q.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back('{golden_f(bus.R_in, bus.K_in), bus.tag_in, cyc});
        end
    end

    task automatic push(input logic [31:0] r, input logic [47:0] k, input logic [TAG_W-1:0] t);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.R_in     = r;
        bus.K_in     = k;
        bus.tag_in   = t;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        check("accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [31:0]      r;
        logic [47:0]      k;
        logic [TAG_W-1:0] tag;
        logic [31:0]      f;
        int               s7;
    } vec_t;

    vec_t        vt[6];
    logic [31:0] rr;
    logic [47:0] kk;
    logic [31:0] bp_r[3];
    logic [47:0] bp_k[3];
    logic [31:0] hold_f;
    logic [TAG_W-1:0] hold_t;
    logic [3:0]  nib;
    bit          got;
    bit          held;
    bit          stalled_prev;
    int          idx;
    int          n_acc;
    int          base;
    int          c0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.R_in      = '0;
        bus.K_in      = '0;
        bus.tag_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_f_out", 64'(bus.f_out), 64'd0);
        check("rst_tag_out", 64'(bus.tag_out), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: worked example, all-zero x (S7 -> 4), S7 row 3 col 15 (-> 12), random
        vt[0] = '{32'hF0AAF0AA, 48'h1B02EFFC7072, 4'd1, 32'h234AA9BB, -1};
        vt[1] = '{32'h00000000, 48'h000000000000, 4'd2, 32'hD8D8DBBC, 4};
        vt[2] = '{32'h00000000, 48'h000000000FC0, 4'd3, golden_f(32'h0, 48'h000000000FC0), 12};
        for (int i = 3; i < 6; i++) begin
            rr = $urandom;
            kk = {16'($urandom), 32'($urandom)};
            vt[i] = '{rr, kk, 4'(i), golden_f(rr, kk), -1};
        end

        chk_lat = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(vt[i].r, vt[i].k, vt[i].tag);
            bus.in_valid = 1'b0;
            if (i == 0) check("stage1_x", 64'(dut.x_reg), 64'h6117BA866527);
            got = 1'b0;
            for (int j = 0; j < 20 && !got; j++) begin
                @(negedge clk);
                got = bus.out_valid;
            end
            check("tbl_out_seen", 64'(got), 64'd1);
            check("tbl_f_out", 64'(bus.f_out), 64'(vt[i].f));
            check("tbl_tag_out", 64'(bus.tag_out), 64'(vt[i].tag));
            if (vt[i].s7 >= 0) begin
                nib = {bus.f_out[32], bus.f_out[12], bus.f_out[22], bus.f_out[7]};
                check("s7_nibble", 64'(nib), 64'(vt[i].s7));
            end
            @(posedge clk);
            #1;
        end

        // Back-to-back stream: one accept per cycle, contiguous results
        out_cyc_q.delete();
        base = n_out;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            rr = $urandom;
            kk = {16'($urandom), 32'($urandom)};
            push(rr, kk, 4'($urandom));
        end
        bus.in_valid = 1'b0;
        check("stream_accept_cycles", 64'(cyc - c0), 64'd16);
        wait_idle();
        chk_lat = 1'b0;
        check("stream_out_count", 64'(out_cyc_q.size()), 64'd16);
        if (out_cyc_q.size() == 16)
            check("stream_contiguous", 64'(out_cyc_q[15] - out_cyc_q[0]), 64'd15);

        // Backpressure: out_ready low for 5 cycles while 3 operands are offered
        for (int i = 0; i < 3; i++) begin
            bp_r[i] = $urandom;
            bp_k[i] = {16'($urandom), 32'($urandom)};
        end
        base = n_out;
        bus.out_ready = 1'b0;
        idx = 0;
        held = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 3) begin
                bus.in_valid = 1'b1;
                bus.R_in     = bp_r[idx];
                bus.K_in     = bp_k[idx];
                bus.tag_in   = 4'(8 + idx);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid) begin
                if (!held) begin
                    held   = 1'b1;
                    hold_f = bus.f_out;
                    hold_t = bus.tag_out;
                end else begin
                    check("stall_f_stable", 64'(bus.f_out), 64'(hold_f));
                    check("stall_tag_stable", 64'(bus.tag_out), 64'(hold_t));
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", 64'(idx), 64'(LAT));
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);

        // Full pipe, pop and push in the same cycle
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        if (idx < 3) begin
            bus.R_in = bp_r[idx];
            bus.K_in = bp_k[idx];
        end else begin
            bus.R_in = $urandom;
            bus.K_in = {16'($urandom), 32'($urandom)};
        end
        bus.tag_in = 4'(8 + idx);
        n_acc = idx + 1;
        @(negedge clk);
        check("full_in_ready", 64'(bus.in_ready), 64'd1);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("no_bubble_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_idle();
        check("bp_out_count", 64'(n_out - base), 64'(n_acc));

        // Randomized traffic with random backpressure
        base = n_out;
        n_acc = 0;
        stalled_prev = 1'b0;
        for (int c = 0; c < 300; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.R_in      = $urandom;
            bus.K_in      = {16'($urandom), 32'($urandom)};
            bus.tag_in    = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stalled_prev) begin
                check("rnd_stall_f", 64'(bus.f_out), 64'(hold_f));
                check("rnd_stall_tag", 64'(bus.tag_out), 64'(hold_t));
            end
            stalled_prev = bus.out_valid & ~bus.out_ready;
            hold_f = bus.f_out;
            hold_t = bus.tag_out;
            if (bus.in_valid && bus.in_ready) n_acc++;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        check("rnd_out_count", 64'(n_out - base), 64'(n_acc));

        // Reset with two operands in flight
        bus.out_ready = 1'b0;
        push($urandom, {16'($urandom), 32'($urandom)}, 4'd5);
        push($urandom, {16'($urandom), 32'($urandom)}, 4'd6);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_f_out", 64'(bus.f_out), 64'd0);
        check("midrst_tag_out", 64'(bus.tag_out), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        base = n_out;
        chk_lat = 1'b1;
        push(32'hF0AAF0AA, 48'h1B02EFFC7072, 4'd7);
        bus.in_valid = 1'b0;
        got = 1'b0;
        for (int j = 0; j < 20 && !got; j++) begin
            @(negedge clk);
            got = bus.out_valid;
        end
        check("postrst_out_seen", 64'(got), 64'd1);
        check("postrst_f_out", 64'(bus.f_out), 64'h234AA9BB);
        @(posedge clk);
        #1;
        wait_idle();
        chk_lat = 1'b0;
        check("postrst_out_count", 64'(n_out - base), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
